uart_receiver: RTL and testbench

- 8N1 UART receiver with 16x oversampling. Sits on the serial RX pin (a GPIO line) and delivers each received byte to the system with a one-clock strobe.
- Default timing gives 9615 baud from the 50 MHz system clock: 325 clocks per sample tick, 16 ticks per bit, 5200 clocks per bit.
- Used by the computer top level and by benches as a serial monitor.

---
 rtl/uart_receiver.sv | 89 ++++++++
 tb/tb_uart_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, 16x oversampled, centre-sampled, one-clock byte strobe
module uart_receiver #(
    parameter int CLKS_PER_TICK = 325,
    parameter int OVERSAMPLE    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_ready
);
    localparam int PW = CLKS_PER_TICK > 1 ? $clog2(CLKS_PER_TICK) : 1;
    localparam int TW = OVERSAMPLE > 2 ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLKS_PER_TICK - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rxs;
    logic [PW-1:0] presc;
    logic [TW-1:0] tcnt;
    logic [2:0]    bcnt;
    logic [7:0]    sr;
    logic          tick;

    assign rxs  = sync[1];
    assign tick = presc == P_LAST;

    // two-flop synchronizer for the asynchronous rx pin, idling high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], rx};
    end

    // frame FSM: prescaler, per-state tick count, bit count, shift register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            presc      <= '0;
            tcnt       <= '0;
            bcnt       <= '0;
            sr         <= '0;
            data       <= '0;
            data_ready <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            presc      <= (state == IDLE || state == WAIT_HIGH || tick) ? '0 : presc + PW'(1);
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (!rxs) state <= START;
                end
                START: if (tick) begin
                    if (tcnt == T_HALF) begin
                        tcnt  <= '0;
                        bcnt  <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else tcnt <= tcnt + TW'(1);
                end
                DATA: if (tick) begin
                    if (tcnt == T_FULL) begin
                        tcnt <= '0;
                        sr   <= {rxs, sr[7:1]};
                        bcnt <= bcnt + 3'd1;
                        if (bcnt == 3'd7) state <= STOP;
                    end else tcnt <= tcnt + TW'(1);
                end
                STOP: if (tick) begin
                    if (tcnt == T_FULL) begin
                        tcnt <= '0;
                        if (rxs) begin
                            data       <= sr;
                            data_ready <= 1'b1;
                            state      <= IDLE;
                        end else state <= WAIT_HIGH;
                    end else tcnt <= tcnt + TW'(1);
                end
                WAIT_HIGH: begin
                    tcnt <= '0;
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven and randomized checks of uart_receiver at a scaled-down bit rate
module tb_uart_receiver;
    localparam int CPT = 4;
    localparam int OS  = 16;
    localparam int BIT = CPT * OS;
    localparam int LAT = (OS / 2) * CPT + 9 * OS * CPT + 3;

    typedef struct {
        logic [7:0] b;
        int         bc;
        logic       stop;
        int         hold;
        int         gap;
        int         exp_n;
        logic [7:0] exp_data;
        logic       chk_lat;
        logic       chk_space;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       data_ready;

    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    logic [7:0] got_q[$];
    int         got_t[$];
    logic [7:0] exp_q[$];
    logic [7:0] model_last;
    logic [7:0] held = 8'h00;
    logic       prev_dr = 1'b0;
    vec_t       vecs[9];
    vec_t       v;
    int         t0;
    int         last_t;
    logic [7:0] r_b;
    int         r_bc;
    logic       r_stop;
    logic [7:0] partial;

    uart_receiver #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(OS)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .data_ready(data_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            held    = 8'h00;
            prev_dr = 1'b0;
        end else begin
            if (data_ready && prev_dr) begin
                total++;
                $display("FAIL dr_width: data_ready high on two consecutive clocks at cycle %0d", cyc);
            end
            if (data_ready) begin
                got_q.push_back(data);
                got_t.push_back(cyc);
                held = data;
            end else if (data !== held) begin
                total++;
                $display("FAIL data_hold_mon: data changed to %h without strobe, held %h", data, held);
                held = data;
            end
            prev_dr = data_ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bc, input logic stop);
        rx = 1'b0;
        wait_clks(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(bc);
        end
        rx = stop;
        wait_clks(bc);
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_q.push_back(b);
            model_last = b;
        end
    endfunction

    initial begin
        vecs[0] = '{8'h74, BIT,     1'b1, 0, 2, 1, 8'h74, 1'b1, 1'b0};
        vecs[1] = '{8'h00, BIT,     1'b1, 0, 0, 1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, BIT,     1'b1, 0, 0, 1, 8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'h55, BIT,     1'b1, 0, 0, 1, 8'h55, 1'b0, 1'b1};
        vecs[4] = '{8'hA5, BIT,     1'b1, 0, 2, 1, 8'hA5, 1'b0, 1'b1};
        vecs[5] = '{8'h6E, BIT - 2, 1'b1, 0, 1, 1, 8'h6E, 1'b0, 1'b0};
        vecs[6] = '{8'h6E, BIT + 2, 1'b1, 0, 1, 1, 8'h6E, 1'b0, 1'b0};
        vecs[7] = '{8'h81, BIT,     1'b0, 3, 2, 0, 8'h6E, 1'b0, 1'b0};
        vecs[8] = '{8'h42, BIT,     1'b1, 0, 2, 1, 8'h42, 1'b0, 1'b0};

        #2 rst = 1'b0;
        wait_clks(3);
        check("rst_data", data, 8'h00);
        check("rst_dr", data_ready, 1'b0);
        rst = 1'b1;
        wait_clks(2 * BIT);
        check("idle_strobes", got_q.size(), 0);
        check("idle_data", data, 8'h00);

        last_t = 0;
        for (int i = 0; i < 9; i++) begin
            v  = vecs[i];
            t0 = cyc;
            send_frame(v.b, v.bc, v.stop);
            if (v.hold > 0) begin
                rx = 1'b0;
                wait_clks(v.hold * v.bc);
            end
            rx = 1'b1;
            check("strobes", got_q.size(), v.exp_n);
            if (got_q.size() > 0) begin
                check("rx_byte", got_q[0], v.exp_data);
                if (v.chk_lat) check_rng("latency", got_t[0] - t0, LAT - 1, LAT + 1);
                if (v.chk_space) check("spacing", got_t[0] - last_t, 10 * v.bc);
                last_t = got_t[0];
            end
            got_q.delete();
            got_t.delete();
            if (v.gap > 0) wait_clks(v.gap * v.bc);
            check("data_hold", data, v.exp_data);
        end

        rx = 1'b0;
        wait_clks(12);
        rx = 1'b1;
        wait_clks(2 * BIT);
        check("glitch_strobes", got_q.size(), 0);
        check("glitch_data", data, 8'h42);
        send_frame(8'h3C, BIT, 1'b1);
        wait_clks(BIT);
        check("after_glitch_n", got_q.size(), 1);
        if (got_q.size() > 0) check("after_glitch_byte", got_q[0], 8'h3C);
        got_q.delete();
        got_t.delete();

        partial = 8'hC3;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            wait_clks(BIT);
        end
        rx = partial[4];
        wait_clks(BIT / 2);
        rst = 1'b0;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_dr", data_ready, 1'b0);
        rx = 1'b1;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(2 * BIT);
        check("midrst_strobes", got_q.size(), 0);
        check("midrst_hold", data, 8'h00);
        send_frame(8'h99, BIT, 1'b1);
        wait_clks(BIT);
        check("after_rst_n", got_q.size(), 1);
        if (got_q.size() > 0) check("after_rst_byte", got_q[0], 8'h99);
        got_q.delete();
        got_t.delete();

        model_last = 8'h99;
        for (int n = 0; n < 24; n++) begin
            r_b    = 8'($urandom);
            r_bc   = $urandom_range(BIT - 2, BIT + 2);
            r_stop = ($urandom_range(0, 4) != 0);
            model_frame(r_b, r_stop);
            send_frame(r_b, r_bc, r_stop);
            if (!r_stop) begin
                wait_clks($urandom_range(0, 2) * r_bc + 1);
                rx = 1'b1;
                wait_clks(r_bc);
            end else if ($urandom_range(0, 1) == 1) begin
                wait_clks(r_bc);
            end
            check("rand_count", got_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
                check("rand_byte", got_q[k], exp_q[k]);
            check("rand_hold", data, model_last);
            got_q.delete();
            got_t.delete();
            exp_q.delete();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
